aes_round_sequencer: RTL and testbench

- Iterative AES-128 encryption controller; owns the 128-bit state register and performs AddRoundKey (state XOR subkey) internally.
- Sequences round 0 (initial AddRoundKey) and rounds 1..NR against an external combinational round-function datapath (SubBytes/ShiftRows/MixColumns).
- Fetches one subkey per round from the key-expansion block over a request/valid handshake.
- Sits between the host-side cipher interface and the key schedule.

---
 rtl/aes_round_sequencer.sv | 135 +++++++++++++
 tb/tb_aes_round_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative AES-128 encryption controller. Owns the 128-bit cipher state and
// performs AddRoundKey internally. SubBytes/ShiftRows/MixColumns are done by an
// external combinational round-function datapath that sees rf_state and
// returns rf_out in the same cycle. One subkey per round is fetched from the
// key-expansion block over a level-held request / valid handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, plaintext      host request; plaintext captured when start accepted
//   abort                 synchronous cancel of the operation in progress
//   busy, done            busy while running; done = one-cycle completion pulse
//   ciphertext            result, held until the next completion
//   key_req, key_round    subkey request and index of the wanted subkey
//   key_valid, subkey     key-schedule response (consumed while key_req=1)
//   rf_state, rf_last     state and final-round flag to the round function
//   rf_out                combinational round-function result for rf_state
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR = 10              // number of cipher rounds, 1..15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] plaintext,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext,
    output logic         key_req,
    output logic [3:0]   key_round,
    input  logic         key_valid,
    input  logic [127:0] subkey,
    output logic [127:0] rf_state,
    output logic         rf_last,
    input  logic [127:0] rf_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_KEY  = 1'b1;

    // Round index of the final round, at the width of the round counter.
    localparam logic [3:0] NR_W = 4'(NR);

    logic [0:0]   fsm_reg,        fsm_next;
    logic [3:0]   round_reg,      round_next;
    logic [127:0] state_reg,      state_next;
    logic [127:0] ciphertext_reg, ciphertext_next;
    logic         done_reg,       done_next;

    // AddRoundKey operand: round 0 whitens the raw plaintext held in the
    // state register; every later round keys the round-function output.
    logic [127:0] ark_src;
    logic [127:0] ark_out;
    logic         last_round;
    logic         first_round;

    assign first_round = (round_reg == 4'd0);
    assign last_round  = (round_reg == NR_W);
    assign ark_src     = first_round ? state_reg : rf_out;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ark
            assign ark_out[32*gi +: 32] = ark_src[32*gi +: 32] ^ subkey[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        fsm_next        = fsm_reg;
        round_next      = round_reg;
        state_next      = state_reg;
        ciphertext_next = ciphertext_reg;
        done_next       = 1'b0;

        case (fsm_reg)
            S_IDLE: begin
                // abort alongside start cancels the request before it begins.
                if (start && !abort) begin
                    state_next = plaintext;
                    round_next = 4'd0;
                    fsm_next   = S_KEY;
                end
            end
            S_KEY: begin
                if (abort) begin
                    // Partial state is left as is; only the round restarts.
                    fsm_next   = S_IDLE;
                    round_next = 4'd0;
                end else if (key_valid) begin
                    if (last_round) begin
                        ciphertext_next = ark_out;
                        done_next       = 1'b1;
                        round_next      = 4'd0;
                        fsm_next        = S_IDLE;
                    end else begin
                        state_next = ark_out;
                        round_next = round_reg + 4'd1;
                    end
                end
            end
            default: begin
                fsm_next   = S_IDLE;
                round_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg        <= S_IDLE;
            round_reg      <= 4'd0;
            state_reg      <= '0;
            ciphertext_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            fsm_reg        <= fsm_next;
            round_reg      <= round_next;
            state_reg      <= state_next;
            ciphertext_reg <= ciphertext_next;
            done_reg       <= done_next;
        end
    end

    assign busy       = (fsm_reg == S_KEY);
    assign key_req    = (fsm_reg == S_KEY);
    assign key_round  = round_reg;
    assign done       = done_reg;
    assign ciphertext = ciphertext_reg;
    assign rf_state   = state_reg;
    assign rf_last    = last_round;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Directed bench for aes_round_sequencer. Provides a behavioural AES round
// function on rf_out and a key-schedule responder with selectable timing
// (always ready, 0-3 random wait cycles per round, or manually driven).
// Expected ciphertexts are the published FIPS-197 vectors.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ARK_A = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
    logic         key_req;
    logic [3:0]   key_round;
    logic         key_valid;
    logic [127:0] subkey;
    logic [127:0] rf_state;
    logic         rf_last;
    logic [127:0] rf_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] rk [0:10];
    int           kv_mode = 0;       // 0 always valid, 1 random waits, 2 manual
    int           wait_cnt = 0;
    int           last_rnd = -1;
    int           acc_log [$];

    aes_round_sequencer #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext),
        .key_req    (key_req),
        .key_round  (key_round),
        .key_valid  (key_valid),
        .subkey     (subkey),
        .rf_state   (rf_state),
        .rf_last    (rf_last),
        .rf_out     (rf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);   // x^254 = x^-1, 0 -> 0
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] o [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[rw+4*c] = b[rw+4*((c+rw)%4)];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int rw = 0; rw < 4; rw++) o[rw+4*c] = t[rw+4*c];
            end else begin
                o[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                o[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                o[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                o[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
        return r;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
                tmp = tmp ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- environment models ----------------
    assign rf_out = aes_round(rf_state, rf_last);
    assign subkey = (key_round <= 4'd10) ? rk[key_round] : '0;

    always @(negedge clk) begin
        if (kv_mode == 0) begin
            key_valid = 1'b1;
        end else if (kv_mode == 1) begin
            if (!key_req) begin
                last_rnd  = -1;
                key_valid = 1'b0;
            end else begin
                if (int'(key_round) != last_rnd) begin
                    last_rnd = int'(key_round);
                    wait_cnt = $urandom_range(0, 3);
                end
                if (wait_cnt == 0) key_valid = 1'b1;
                else begin
                    key_valid = 1'b0;
                    wait_cnt--;
                end
            end
        end
        if (key_req && key_valid) acc_log.push_back(int'(key_round));
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic launch(input logic [127:0] pt);
        @(negedge clk);
        start     = 1'b1;
        plaintext = pt;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Entered at the negedge after the start edge; returns at the done negedge.
    task automatic wait_done(input string tag, output int edges, output int gaps,
                             output int rl_bad, output int rl_hits);
        edges = 0; gaps = 0; rl_bad = 0; rl_hits = 0;
        while (!done && edges < 100) begin
            if (!busy) gaps++;
            if (rf_last !== (key_round == 4'd10)) rl_bad++;
            if (rf_last) rl_hits++;
            @(negedge clk);
            edges++;
        end
        check({tag, "_done_seen"}, 128'(done), 128'd1);
        check({tag, "_busy_in_done"}, 128'(busy), 128'd0);
    endtask

    task automatic wait_round(input string tag, input logic [3:0] r);
        int n = 0;
        while (key_round !== r && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reach_round"}, 128'(key_round), 128'(r));
    endtask

    int edges, gaps, rl_bad, rl_hits, done_cnt;
    logic [127:0] snap_state, snap_ct;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; key_valid = 1'b0; plaintext = '0;
        load_key(KEY_A);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_key_req", 128'(key_req), 128'd0);
        check("rst_ct", ciphertext, 128'd0);
        check("rst_state", rf_state, 128'd0);
        check("rst_rf_last", 128'(rf_last), 128'd0);
        rst_n = 1'b1;

        // 1: ideal key source, FIPS-197 C.1
        kv_mode = 0;
        launch(PT_A);
        check("t1_state_pt", rf_state, PT_A);
        check("t1_busy", 128'(busy), 128'd1);
        check("t1_round0", 128'(key_round), 128'd0);
        @(negedge clk);
        check("t1_state_ark0", rf_state, ARK_A);
        check("t1_round1", 128'(key_round), 128'd1);
        wait_done("t1", edges, gaps, rl_bad, rl_hits);
        check("t1_latency", 128'(edges + 1), 128'd11);
        check("t1_ct", ciphertext, CT_A);
        check("t1_rf_last", 128'(rl_bad), 128'd0);
        @(negedge clk);
        check("t1_done_one_cycle", 128'(done), 128'd0);
        $display("t1 ideal source: ct=%h edges=%0d", ciphertext, edges + 1);

        // 2: random 0-3 wait cycles per round
        kv_mode = 1;
        acc_log.delete();
        launch(PT_A);
        wait_done("t2", edges, gaps, rl_bad, rl_hits);
        check("t2_ct", ciphertext, CT_A);
        check("t2_busy_gaps", 128'(gaps), 128'd0);
        check("t2_accept_count", 128'(acc_log.size()), 128'd11);
        for (int i = 0; i < acc_log.size() && i < 11; i++)
            check($sformatf("t2_key_round_%0d", i), 128'(acc_log[i]), 128'(i));
        $display("t2 random waits: ct=%h cycles=%0d", ciphertext, edges + 1);
        kv_mode = 0;

        // 3: start during round 5 ignored; start in done cycle accepted
        launch(PT_A);
        wait_round("t3", 4'd5);
        start = 1'b1; plaintext = PT_B;
        @(negedge clk);
        start = 1'b0;
        check("t3_still_busy", 128'(busy), 128'd1);
        check("t3_round6", 128'(key_round), 128'd6);
        wait_done("t3a", edges, gaps, rl_bad, rl_hits);
        check("t3a_ct", ciphertext, CT_A);
        start = 1'b1; plaintext = PT_B;
        load_key(KEY_B);
        @(negedge clk);
        start = 1'b0;
        check("t3b_restart_busy", 128'(busy), 128'd1);
        check("t3b_state_pt", rf_state, PT_B);
        wait_done("t3b", edges, gaps, rl_bad, rl_hits);
        check("t3b_latency", 128'(edges), 128'd11);
        check("t3b_ct", ciphertext, CT_B);
        $display("t3 back-to-back: ct=%h", ciphertext);

        // 4: abort at round 7 together with key_valid
        load_key(KEY_A);
        launch(PT_A);
        wait_round("t4", 4'd7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_busy", 128'(busy), 128'd0);
        check("t4_key_req", 128'(key_req), 128'd0);
        check("t4_round", 128'(key_round), 128'd0);
        check("t4_ct_kept", ciphertext, CT_B);
        done_cnt = 0;
        repeat (15) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("t4_no_done", 128'(done_cnt), 128'd0);
        launch(PT_A);
        wait_done("t4b", edges, gaps, rl_bad, rl_hits);
        check("t4b_ct", ciphertext, CT_A);
        $display("t4 abort then restart: ct=%h", ciphertext);

        // 5: asynchronous reset mid round 4
        load_key(KEY_B);
        launch(PT_B);
        wait_round("t5", 4'd4);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", 128'(busy), 128'd0);
        check("t5_key_req", 128'(key_req), 128'd0);
        check("t5_done", 128'(done), 128'd0);
        check("t5_ct", ciphertext, 128'd0);
        check("t5_state", rf_state, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(PT_B);
        wait_done("t5b", edges, gaps, rl_bad, rl_hits);
        check("t5b_latency", 128'(edges), 128'd11);
        check("t5b_ct", ciphertext, CT_B);
        $display("t5 async reset then restart: ct=%h", ciphertext);

        // 6: key_valid toggling in IDLE; abort+start in IDLE; rf_last window
        @(negedge clk);
        kv_mode = 2;
        snap_state = rf_state;
        snap_ct    = ciphertext;
        repeat (6) begin
            @(negedge clk);
            key_valid = ~key_valid;
        end
        @(negedge clk);
        check("t6_state_hold", rf_state, snap_state);
        check("t6_ct_hold", ciphertext, snap_ct);
        check("t6_idle_busy", 128'(busy), 128'd0);
        check("t6_idle_round", 128'(key_round), 128'd0);
        abort = 1'b1; start = 1'b1; plaintext = PT_A;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("t6_abort_start_busy", 128'(busy), 128'd0);
        check("t6_abort_start_state", rf_state, snap_state);
        kv_mode = 0;
        load_key(KEY_A);
        launch(PT_A);
        wait_done("t6", edges, gaps, rl_bad, rl_hits);
        check("t6_rf_last_decode", 128'(rl_bad), 128'd0);
        check("t6_rf_last_hits", 128'(rl_hits), 128'd1);
        check("t6_ct", ciphertext, CT_A);
        $display("t6 idle key_valid and rf_last: ct=%h", ciphertext);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
